// File: rtl/serial_sub_nbit.sv
// Bit-serial ripple-borrow subtractor: d = a - b - bin, one bit per clock, LSB first.
// Define SERIAL_SUB_OVF_EN to add the signed-overflow output ovf.
module serial_sub_nbit #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] d,
    output logic             bout
`ifdef SERIAL_SUB_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             br_q, br_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             ai, bi, br_next, last_bit;
`ifdef SERIAL_SUB_OVF_EN
    logic             ovf_q, ovf_d;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            res_q   <= '0;
            br_q    <= 1'b0;
            cnt_q   <= '0;
`ifdef SERIAL_SUB_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            res_q   <= res_d;
            br_q    <= br_d;
            cnt_q   <= cnt_d;
`ifdef SERIAL_SUB_OVF_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    assign ai       = a_sh_q[0];
    assign bi       = b_sh_q[0];
    assign br_next  = (~ai & bi) | (~(ai ^ bi) & br_q);
    assign last_bit = (cnt_q == CW'(WIDTH - 1));

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid)  state_d = RUN;
            RUN:     if (last_bit)  state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath: load on accept, shift one bit per RUN cycle, hold otherwise.
    always_comb begin
        a_sh_d = a_sh_q;
        b_sh_d = b_sh_q;
        res_d  = res_q;
        br_d   = br_q;
        cnt_d  = cnt_q;
`ifdef SERIAL_SUB_OVF_EN
        ovf_d  = ovf_q;
`endif
        if (state_q == IDLE && in_valid) begin
            a_sh_d = a;
            b_sh_d = b;
            br_d   = bin;
            cnt_d  = '0;
        end else if (state_q == RUN) begin
            res_d  = {ai ^ bi ^ br_q, res_q[WIDTH-1:1]};
            a_sh_d = a_sh_q >> 1;
            b_sh_d = b_sh_q >> 1;
            br_d   = br_next;
            cnt_d  = cnt_q + CW'(1);
`ifdef SERIAL_SUB_OVF_EN
            // Borrow into MSB vs borrow out of MSB.
            if (last_bit) ovf_d = br_q ^ br_next;
`endif
        end
    end

    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == DONE);
        d         = res_q;
        bout      = br_q;
`ifdef SERIAL_SUB_OVF_EN
        ovf       = ovf_q;
`endif
    end

endmodule
